// File: rtl/fetch_realign_pkg.sv
// Shared types and constants for the fetch realignment buffer.
package fetch_realign_pkg;
    localparam int HALF_BYTES = 2;
    localparam int MAX_VLEN   = 64;

    typedef enum logic {
        ALIGNED = 1'b0,
        HALF    = 1'b1
    } realign_state_e;

    // addr is sized for the widest supported VLEN; the top uses the low VLEN bits.
    typedef struct packed {
        logic [31:0]         instr;
        logic [MAX_VLEN-1:0] addr;
        logic                rvc;
    } fetch_slot_t;

    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction
endpackage

// File: rtl/fetch_realign_buf.sv
// Splits 32-bit fetch words into up to two instruction slots; 1-cycle registered output.
// Fetch stalls while an output is held unconsumed; FETCH_REALIGN_RVC_EN enables compressed realignment.
module fetch_realign_buf
    import fetch_realign_pkg::*;
#(
    parameter int VLEN = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 fetch_valid_i,
    output logic                 fetch_ready_o,
    input  logic [31:0]          fetch_data_i,
    input  logic [VLEN-1:0]      fetch_addr_i,
    output logic [1:0]           out_valid_o,
    output logic [1:0][31:0]     out_instr_o,
    output logic [1:0][VLEN-1:0] out_addr_o,
    output logic [1:0]           out_rvc_o,
    input  logic                 out_ready_i
);
    logic              w_fire;
    logic [1:0]        w_vld;
    fetch_slot_t [1:0] w_slot;
    logic [1:0]        r_vld;
    fetch_slot_t [1:0] r_slot;

    assign fetch_ready_o = !rst_i && (r_vld == 2'b00 || out_ready_i);
    assign w_fire        = fetch_valid_i && fetch_ready_o;

`ifdef FETCH_REALIGN_RVC_EN
    realign_state_e  r_state, w_nxt_state;
    logic [15:0]     r_pend_half, w_nxt_pend_half;
    logic [VLEN-1:0] r_pend_addr, w_nxt_pend_addr;
    logic [VLEN-1:0] w_hi_addr;
    logic            w_cont;
    logic            w_hi_todo;

    assign w_cont    = (r_state == HALF) && (fetch_addr_i == r_pend_addr + VLEN'(HALF_BYTES));
    assign w_hi_addr = fetch_addr_i + VLEN'(HALF_BYTES);

    always_comb begin
        w_vld           = 2'b00;
        w_slot          = '0;
        w_nxt_state     = ALIGNED;
        w_nxt_pend_half = '0;
        w_nxt_pend_addr = '0;
        w_hi_todo       = 1'b0;
        if (w_cont) begin
            w_vld[0]        = 1'b1;
            w_slot[0].instr = {fetch_data_i[15:0], r_pend_half};
            w_slot[0].addr  = MAX_VLEN'(r_pend_addr);
            w_hi_todo       = 1'b1;
        end else if (fetch_addr_i[1]) begin
            // Only the upper halfword belongs to this fetch.
            if (is_rvc(fetch_data_i[31:16])) begin
                w_vld[0]        = 1'b1;
                w_slot[0].instr = {16'h0, fetch_data_i[31:16]};
                w_slot[0].addr  = MAX_VLEN'(fetch_addr_i);
                w_slot[0].rvc   = 1'b1;
            end else begin
                w_nxt_state     = HALF;
                w_nxt_pend_half = fetch_data_i[31:16];
                w_nxt_pend_addr = fetch_addr_i;
            end
        end else if (!is_rvc(fetch_data_i[15:0])) begin
            w_vld[0]        = 1'b1;
            w_slot[0].instr = fetch_data_i;
            w_slot[0].addr  = MAX_VLEN'(fetch_addr_i);
        end else begin
            w_vld[0]        = 1'b1;
            w_slot[0].instr = {16'h0, fetch_data_i[15:0]};
            w_slot[0].addr  = MAX_VLEN'(fetch_addr_i);
            w_slot[0].rvc   = 1'b1;
            w_hi_todo       = 1'b1;
        end
        if (w_hi_todo) begin
            if (is_rvc(fetch_data_i[31:16])) begin
                w_vld[1]        = 1'b1;
                w_slot[1].instr = {16'h0, fetch_data_i[31:16]};
                w_slot[1].addr  = MAX_VLEN'(w_hi_addr);
                w_slot[1].rvc   = 1'b1;
            end else begin
                w_nxt_state     = HALF;
                w_nxt_pend_half = fetch_data_i[31:16];
                w_nxt_pend_addr = w_hi_addr;
            end
        end
    end
`else
    always_comb begin
        w_vld           = 2'b01;
        w_slot          = '0;
        w_slot[0].instr = fetch_data_i;
        w_slot[0].addr  = MAX_VLEN'(fetch_addr_i);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld  <= '0;
            r_slot <= '0;
        end else if (flush_i) begin
            r_vld <= '0;
        end else if (w_fire) begin
            r_vld  <= w_vld;
            r_slot <= w_slot;
        end else if (out_ready_i) begin
            r_vld <= '0;
        end
`ifdef FETCH_REALIGN_RVC_EN
        if (rst_i || flush_i) begin
            r_state     <= ALIGNED;
            r_pend_half <= '0;
            r_pend_addr <= '0;
        end else if (w_fire) begin
            r_state     <= w_nxt_state;
            r_pend_half <= w_nxt_pend_half;
            r_pend_addr <= w_nxt_pend_addr;
        end
`endif
    end

    assign out_valid_o = r_vld;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            out_instr_o[i] = r_slot[i].instr;
            out_addr_o[i]  = r_slot[i].addr[VLEN-1:0];
            out_rvc_o[i]   = r_slot[i].rvc;
        end
    end
endmodule

// File: tb/tb_fetch_realign_buf.sv
// Randomized scoreboard bench for fetch_realign_buf with halfword-stream reference model.
module tb_fetch_realign_buf;
`ifdef FETCH_REALIGN_RVC_EN
    localparam bit RVC_ON = 1'b1;
`else
    localparam bit RVC_ON = 1'b0;
`endif

    logic             clk_i;
    logic             rst_i;
    logic             flush_i;
    logic             fetch_valid_i;
    logic             fetch_ready_o;
    logic [31:0]      fetch_data_i;
    logic [63:0]      fetch_addr_i;
    logic [1:0]       out_valid_o;
    logic [1:0][31:0] out_instr_o;
    logic [1:0][63:0] out_addr_o;
    logic [1:0]       out_rvc_o;
    logic             out_ready_i;

    fetch_realign_buf #(.VLEN(64)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_data_i  (fetch_data_i),
        .fetch_addr_i  (fetch_addr_i),
        .out_valid_o   (out_valid_o),
        .out_instr_o   (out_instr_o),
        .out_addr_o    (out_addr_o),
        .out_rvc_o     (out_rvc_o),
        .out_ready_i   (out_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct packed {
        logic [1:0]       vld;
        logic [1:0][31:0] instr;
        logic [1:0][63:0] addr;
        logic [1:0]       rvc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_pend   = 1'b0;
    logic [15:0] m_half   = '0;
    logic [63:0] m_paddr  = '0;
    logic [63:0] seq_addr = 64'h8000;

    function automatic logic is16(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    function automatic logic [15:0] rnd_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: turn the fetch into a stream of addressed halfwords and parse it greedily.
    task automatic model_word(input logic [31:0] d, input logic [63:0] a);
        logic [15:0] hw[$];
        logic [63:0] pc;
        exp_t        e;
        logic        k;
        logic        any;
        e   = '0;
        k   = 1'b0;
        any = 1'b0;
        if (!RVC_ON) begin
            e.vld[0]   = 1'b1;
            e.instr[0] = d;
            e.addr[0]  = a;
            any        = 1'b1;
        end else begin
            if (m_pend && a == m_paddr + 64'd2) begin
                hw.push_back(m_half);
                hw.push_back(d[15:0]);
                pc = m_paddr;
            end else begin
                if (!a[1]) hw.push_back(d[15:0]);
                pc = a;
            end
            hw.push_back(d[31:16]);
            m_pend = 1'b0;
            while (hw.size() > 0) begin
                if (is16(hw[0])) begin
                    e.vld[k] = 1'b1; e.instr[k] = {16'h0, hw[0]}; e.addr[k] = pc; e.rvc[k] = 1'b1;
                    k = 1'b1; any = 1'b1; pc = pc + 64'd2;
                    void'(hw.pop_front());
                end else if (hw.size() > 1) begin
                    e.vld[k] = 1'b1; e.instr[k] = {hw[1], hw[0]}; e.addr[k] = pc; e.rvc[k] = 1'b0;
                    k = 1'b1; any = 1'b1; pc = pc + 64'd4;
                    void'(hw.pop_front());
                    void'(hw.pop_front());
                end else begin
                    m_pend = 1'b1; m_half = hw[0]; m_paddr = pc;
                    void'(hw.pop_front());
                end
            end
        end
        if (any) exp_q.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic [63:0] a,
                       input logic rdy, input logic fl, input logic rs);
        @(posedge clk_i);
        #1;
        fetch_valid_i = v;
        fetch_data_i  = d;
        fetch_addr_i  = a;
        out_ready_i   = rdy;
        flush_i       = fl;
        rst_i         = rs;
        @(negedge clk_i);
        if (rst_i || flush_i) begin
            m_pend = 1'b0;
            exp_q.delete();
        end else if (fetch_valid_i && fetch_ready_o) begin
            model_word(fetch_data_i, fetch_addr_i);
            seq_addr = {fetch_addr_i[63:2], 2'b00} + 64'd4;
        end
    endtask

    // Monitor: every consumed output transaction is compared with the oldest expectation.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !flush_i && out_ready_i && out_valid_o != 2'b00) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got valid=%b, expected no output", out_valid_o);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (out_valid_o === e.vld) && (out_instr_o[0] === e.instr[0]) &&
                         (out_addr_o[0] === e.addr[0]) && (out_rvc_o[0] === e.rvc[0]);
                    if (e.vld[1])
                        ok = ok && (out_instr_o[1] === e.instr[1]) &&
                             (out_addr_o[1] === e.addr[1]) && (out_rvc_o[1] === e.rvc[1]);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL sb_txn: got vld=%b i0=%h a0=%h c0=%b i1=%h a1=%h c1=%b, expected vld=%b i0=%h a0=%h c0=%b i1=%h a1=%h c1=%b",
                                 out_valid_o, out_instr_o[0], out_addr_o[0], out_rvc_o[0],
                                 out_instr_o[1], out_addr_o[1], out_rvc_o[1],
                                 e.vld, e.instr[0], e.addr[0], e.rvc[0], e.instr[1], e.addr[1], e.rvc[1]);
                    end
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0;
        fetch_data_i = '0; fetch_addr_i = '0; out_ready_i = 1'b0;

        repeat (3) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", out_valid_o, 2'b00);
        chk("rst_ready", fetch_ready_o, 1'b0);
        chk("rst_instr", {out_instr_o[1], out_instr_o[0]}, 64'h0);
        chk("rst_addr0", out_addr_o[0], 64'h0);
        chk("rst_rvc", out_rvc_o, 2'b00);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("rst_release_ready", fetch_ready_o, 1'b1);

        // Single 32-bit instruction.
        cyc(1'b1, 32'h00A5_0513, 64'h1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("w32_vld", out_valid_o, 2'b01);
        chk("w32_i0", out_instr_o[0], 32'h00A5_0513);
        chk("w32_a0", out_addr_o[0], 64'h1000);
        chk("w32_rvc", out_rvc_o[0], 1'b0);

        // Two compressed instructions.
        cyc(1'b1, 32'h4501_4505, 64'h1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("c2_vld", out_valid_o, RVC_ON ? 2'b11 : 2'b01);
        chk("c2_i0", out_instr_o[0], RVC_ON ? 32'h0000_4505 : 32'h4501_4505);
        chk("c2_rvc", out_rvc_o, RVC_ON ? 2'b11 : 2'b00);
        chk("c2_a0", out_addr_o[0], 64'h1000);
        if (RVC_ON) begin
            chk("c2_i1", out_instr_o[1], 32'h0000_4501);
            chk("c2_a1", out_addr_o[1], 64'h1002);
        end

        // Instruction straddling two words.
        cyc(1'b1, 32'h0513_4505, 64'h1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_00A5, 64'h1004, 1'b1, 1'b0, 1'b0);
        chk("strad1_vld", out_valid_o, 2'b01);
        chk("strad1_i0", out_instr_o[0], RVC_ON ? 32'h0000_4505 : 32'h0513_4505);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("strad2_i0", out_instr_o[0], RVC_ON ? 32'h00A5_0513 : 32'h0000_00A5);
        chk("strad2_a0", out_addr_o[0], RVC_ON ? 64'h1002 : 64'h1004);
        chk("strad2_rvc0", out_rvc_o[0], 1'b0);

        // Discontinuity drops the pending half.
        cyc(1'b1, 32'h0513_4505, 64'h1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h00A5_0513, 64'h2000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("disc_vld", out_valid_o, 2'b01);
        chk("disc_a0", out_addr_o[0], 64'h2000);
        chk("disc_i0", out_instr_o[0], 32'h00A5_0513);

        // Flush drops pending and the word handshaken in the flush cycle.
        cyc(1'b1, 32'h0513_4505, 64'h1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h4501_4505, 64'h3000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_vld", out_valid_o, 2'b00);
        cyc(1'b1, 32'h4505_0000, 64'h3002, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_next_vld", out_valid_o, 2'b01);
        chk("flush_next_i0", out_instr_o[0], RVC_ON ? 32'h0000_4505 : 32'h4505_0000);
        chk("flush_next_a0", out_addr_o[0], 64'h3002);
        chk("flush_next_rvc0", out_rvc_o[0], RVC_ON);

        // Pending half at the top of the address space wraps to 0.
        cyc(1'b1, 32'h0513_0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_00A5, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("wrap_first_vld", out_valid_o, RVC_ON ? 2'b00 : 2'b01);
        cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("wrap_vld", out_valid_o, RVC_ON ? 2'b11 : 2'b01);
        chk("wrap_i0", out_instr_o[0], RVC_ON ? 32'h00A5_0513 : 32'h0000_00A5);
        chk("wrap_a0", out_addr_o[0], RVC_ON ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0);

        // Stall for five cycles, then reset mid-stall.
        cyc(1'b1, 32'h4501_4505, 64'h4000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h00A5_0513, 64'h4004, 1'b0, 1'b0, 1'b0);
            chk("stall_ready", fetch_ready_o, 1'b0);
            chk("stall_vld", out_valid_o, RVC_ON ? 2'b11 : 2'b01);
            chk("stall_i0", out_instr_o[0], RVC_ON ? 32'h0000_4505 : 32'h4501_4505);
            chk("stall_a0", out_addr_o[0], 64'h4000);
        end
        cyc(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_rst_ready", fetch_ready_o, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_rst_vld", out_valid_o, 2'b00);
        chk("stall_rst_i0", out_instr_o[0], 32'h0);
        chk("post_rst_ready", fetch_ready_o, 1'b1);

        // Randomized traffic: mostly sequential words with jumps, stalls, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a;
            logic [31:0] d;
            d = {rnd_half(), rnd_half()};
            case ($urandom_range(0, 19))
                0:       a = {32'h0, $urandom} & ~64'h1;
                1:       a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 7)) * 64'd2;
                default: a = seq_addr;
            endcase
            cyc($urandom_range(0, 3) != 0, d, a, $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end
        repeat (4) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("sb_drain", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
